// File: rtl/hp_manager.sv
// hp_manager: tracks both tanks' health, hit cooldowns and round state.
module hp_manager #(
  parameter int HP_MAX = 200,
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       hit_our,
  input  logic [7:0] dmg_our,
  input  logic       hit_enemy,
  input  logic [7:0] dmg_enemy,
  input  logic       vblnk,
  output logic [7:0] HP_our_state,
  output logic [7:0] HP_enemy_state,
  output logic       immune_our,
  output logic       immune_enemy,
  output logic [1:0] round_state
);
  typedef enum logic [1:0] {IDLE = 2'd0, PLAYING = 2'd1, OVER = 2'd2} state_t;
  localparam logic [7:0] HP_FULL = 8'(HP_MAX);
  localparam logic [5:0] CD_LOAD = 6'(COOLDOWN_FRAMES);
  state_t state_q, state_d;
  logic [7:0] hp_our_q, hp_our_d, hp_enemy_q, hp_enemy_d;
  logic [5:0] cd_our_q, cd_our_d, cd_enemy_q, cd_enemy_d;
  logic vblnk_q, tick, acc_our, acc_enemy;
  always_comb begin
    tick = vblnk & ~vblnk_q;
    acc_our = (state_q == PLAYING) && hit_our && (cd_our_q == 6'd0) && (dmg_our != 8'd0);
    acc_enemy = (state_q == PLAYING) && hit_enemy && (cd_enemy_q == 6'd0) && (dmg_enemy != 8'd0);
    hp_our_d = new_game ? HP_FULL : !acc_our ? hp_our_q :
               (dmg_our >= hp_our_q) ? 8'd0 : hp_our_q - dmg_our;
    hp_enemy_d = new_game ? HP_FULL : !acc_enemy ? hp_enemy_q :
                 (dmg_enemy >= hp_enemy_q) ? 8'd0 : hp_enemy_q - dmg_enemy;
    // a reload takes precedence over a same-cycle frame tick
    cd_our_d = new_game ? 6'd0 : acc_our ? CD_LOAD :
               (tick && cd_our_q != 6'd0) ? cd_our_q - 6'd1 : cd_our_q;
    cd_enemy_d = new_game ? 6'd0 : acc_enemy ? CD_LOAD :
                 (tick && cd_enemy_q != 6'd0) ? cd_enemy_q - 6'd1 : cd_enemy_q;
    state_d = new_game ? PLAYING :
              (state_q == PLAYING && (hp_our_d == 8'd0 || hp_enemy_d == 8'd0)) ? OVER : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hp_our_q <= HP_FULL;
      hp_enemy_q <= HP_FULL;
      cd_our_q <= 6'd0;
      cd_enemy_q <= 6'd0;
      vblnk_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hp_our_q <= hp_our_d;
      hp_enemy_q <= hp_enemy_d;
      cd_our_q <= cd_our_d;
      cd_enemy_q <= cd_enemy_d;
      vblnk_q <= vblnk;
    end
  end
  assign HP_our_state = hp_our_q;
  assign HP_enemy_state = hp_enemy_q;
  assign immune_our = cd_our_q != 6'd0;
  assign immune_enemy = cd_enemy_q != 6'd0;
  assign round_state = state_q;
endmodule

// File: tb/tb_hp_manager.sv
// tb_hp_manager: directed checks of health, cooldown and round sequencing.
module tb_hp_manager;
  logic clk = 1'b0, rst, new_game, hit_our, hit_enemy, vblnk;
  logic [7:0] dmg_our, dmg_enemy;
  logic [7:0] hp_our, hp_enemy, hp_our1, hp_enemy1;
  logic imm_our, imm_enemy, imm_our1, imm_enemy1;
  logic [1:0] rs, rs1;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  hp_manager u_dut (
    .clk(clk), .rst(rst), .new_game(new_game), .hit_our(hit_our), .dmg_our(dmg_our),
    .hit_enemy(hit_enemy), .dmg_enemy(dmg_enemy), .vblnk(vblnk),
    .HP_our_state(hp_our), .HP_enemy_state(hp_enemy), .immune_our(imm_our),
    .immune_enemy(imm_enemy), .round_state(rs)
  );
  hp_manager #(.HP_MAX(100), .COOLDOWN_FRAMES(0)) u_nocd (
    .clk(clk), .rst(rst), .new_game(new_game), .hit_our(hit_our), .dmg_our(dmg_our),
    .hit_enemy(hit_enemy), .dmg_enemy(dmg_enemy), .vblnk(vblnk),
    .HP_our_state(hp_our1), .HP_enemy_state(hp_enemy1), .immune_our(imm_our1),
    .immune_enemy(imm_enemy1), .round_state(rs1)
  );
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse(input logic ng, input logic ho, input int d_o, input logic he, input int d_e);
    new_game = ng; hit_our = ho; dmg_our = 8'(d_o); hit_enemy = he; dmg_enemy = 8'(d_e);
    step();
    new_game = 0; hit_our = 0; dmg_our = 0; hit_enemy = 0; dmg_enemy = 0;
  endtask
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      vblnk = 1; step();
      vblnk = 0; step();
    end
  endtask
  initial begin
    rst = 1; new_game = 0; hit_our = 0; hit_enemy = 0; dmg_our = 0; dmg_enemy = 0; vblnk = 0;
    step(); step();
    rst = 0;
    chk("rst_hp_our", hp_our, 200);
    chk("rst_hp_enemy", hp_enemy, 200);
    chk("rst_immune", {imm_our, imm_enemy}, 0);
    chk("rst_state", rs, 0);
    pulse(0, 1, 50, 0, 0);
    chk("idle_hit_ignored", hp_our, 200);
    pulse(1, 0, 0, 0, 0);
    chk("ng_state", rs, 1);
    pulse(0, 1, 50, 0, 0);
    chk("hit1_hp", hp_our, 150);
    chk("hit1_immune", imm_our, 1);
    chk("hit1_state", rs, 1);
    frames(10);
    pulse(0, 1, 50, 0, 0);
    chk("cooldown_reject", hp_our, 150);
    frames(19);
    chk("immune_29_ticks", imm_our, 1);
    frames(1);
    chk("immune_30_ticks", imm_our, 0);
    pulse(0, 1, 50, 0, 0);
    chk("hit2_hp", hp_our, 100);
    pulse(0, 0, 0, 1, 0);
    chk("zero_dmg_hp", hp_enemy, 200);
    chk("zero_dmg_immune", imm_enemy, 0);
    pulse(0, 0, 0, 1, 180);
    chk("enemy_hp20", hp_enemy, 20);
    frames(30);
    chk("enemy_cd_done", imm_enemy, 0);
    vblnk = 1;
    pulse(0, 0, 0, 1, 255);
    vblnk = 0; step();
    chk("enemy_sat_zero", hp_enemy, 0);
    chk("enemy_over", rs, 2);
    chk("load_beats_tick", imm_enemy, 1);
    frames(29);
    chk("over_cd_29", imm_enemy, 1);
    pulse(0, 1, 50, 1, 50);
    chk("over_hit_ignored", hp_our, 100);
    chk("over_hold", rs, 2);
    frames(1);
    chk("over_cd_counts", imm_enemy, 0);
    pulse(1, 0, 0, 0, 0);
    chk("restart_hp", {hp_our, hp_enemy}, {8'd200, 8'd200});
    chk("restart_state", rs, 1);
    pulse(0, 1, 200, 1, 255);
    chk("both_zero", {hp_our, hp_enemy}, 0);
    chk("both_over", rs, 2);
    pulse(1, 0, 0, 0, 0);
    chk("ng_after_both", {hp_our, hp_enemy, 6'd0, rs}, {8'd200, 8'd200, 6'd0, 2'd1});
    pulse(1, 1, 50, 0, 0);
    chk("ng_prio_hp", hp_our, 200);
    chk("ng_prio_immune", imm_our, 0);
    pulse(0, 1, 50, 0, 0);
    chk("pre_rst_hp", hp_our, 150);
    rst = 1; step(); rst = 0;
    chk("mid_rst_state", rs, 0);
    chk("mid_rst_hp", hp_our, 200);
    chk("mid_rst_immune", imm_our, 0);
    pulse(0, 1, 50, 0, 0);
    chk("post_rst_ignored", hp_our, 200);
    pulse(1, 0, 0, 0, 0);
    pulse(0, 1, 30, 0, 0);
    chk("nocd_hit1", hp_our1, 70);
    pulse(0, 1, 30, 0, 0);
    chk("nocd_hit2", hp_our1, 40);
    chk("nocd_immune", imm_our1, 0);
    chk("cd_consec_reject", hp_our, 170);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/hp_manager.md
HP_MANAGER -- requirements
Module: hp_manager

Interface
REQ-001 Parameter HP_MAX, default 200, meaning full-health value loaded at reset and new game (legal range 1..255).
REQ-002 Parameter COOLDOWN_FRAMES, default 30, meaning frames of hit immunity after an accepted hit (legal range 0..63).
REQ-003 clk  input  1  system/pixel clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 new_game  input  1  one-cycle pulse; starts or restarts a round.
REQ-006 hit_our  input  1  one-cycle pulse; own tank was hit.
REQ-007 dmg_our  input  8  damage applied with hit_our; sampled only in the cycle hit_our=1.
REQ-008 hit_enemy  input  1  one-cycle pulse; enemy tank was hit.
REQ-009 dmg_enemy  input  8  damage applied with hit_enemy; sampled only in the cycle hit_enemy=1.
REQ-010 vblnk  input  1  vertical blanking from the timing chain; its rising edge is the frame tick.
REQ-011 HP_our_state  output  8  own health, registered; feeds the HP bar and game-end stage.
REQ-012 HP_enemy_state  output  8  enemy health, registered.
REQ-013 immune_our  output  1  high while own cooldown counter is non-zero.
REQ-014 immune_enemy  output  1  high while enemy cooldown counter is non-zero.
REQ-015 round_state  output  2  0=IDLE, 1=PLAYING, 2=OVER; 3 is never driven.

Function
REQ-016 FSM states IDLE, PLAYING, OVER; round_state is the registered encoding of the current state.
REQ-017 Frame tick = vblnk high in this cycle AND low in the previous cycle, using a one-flop vblnk delay register.
REQ-018 new_game=1 in any state: next cycle both HP outputs = HP_MAX, both cooldowns = 0, state = PLAYING.
REQ-019 new_game has priority over every other event in the same cycle; coincident hits are discarded.
REQ-020 IDLE and OVER: hit pulses ignored; HP values held; cooldowns still count down on frame ticks.
REQ-021 PLAYING, hit_our=1, own cooldown=0, dmg_our!=0: accepted; HP_our_state <= 0 if dmg_our >= HP_our_state, else HP_our_state - dmg_our; own cooldown <= COOLDOWN_FRAMES.
REQ-022 Enemy side follows identical rules with hit_enemy, dmg_enemy and the enemy cooldown.
REQ-023 Hit with cooldown!=0 or dmg=0: rejected; no HP change; cooldown not reloaded.
REQ-024 Subtraction saturates at 0; HP never wraps or exceeds HP_MAX.
REQ-025 Latency: an accepted hit in cycle N is visible on the HP output and immune flag in cycle N+1.
REQ-026 Cooldown counters (6 bit) decrement by 1 per frame tick while non-zero and hold at 0.
REQ-027 A cooldown load and a frame tick in the same cycle: load wins (counter = COOLDOWN_FRAMES).
REQ-028 COOLDOWN_FRAMES=0: every non-zero-damage hit is accepted, even hits in consecutive cycles.
REQ-029 hit_our and hit_enemy in the same cycle: both evaluated independently and both may be accepted.
REQ-030 PLAYING -> OVER in the cycle after either HP becomes 0, together with the HP update; if both reach 0 simultaneously, still OVER, and both outputs read 0.
REQ-031 OVER -> PLAYING only via new_game; IDLE -> PLAYING only via new_game.

Reset
REQ-032 rst=1: next cycle HP_our_state=HP_enemy_state=HP_MAX, cooldowns=0, immune flags=0, round_state=IDLE, vblnk delay flop=0.
REQ-033 rst has priority over new_game and all hits; rst asserted mid-round discards the round and returns to IDLE.

Verification
REQ-034 Reset, new_game, hit_our with dmg_our=50 -> HP_our_state=150 next cycle, immune_our=1, round_state=1.
REQ-035 Second hit_our (dmg 50) 10 frames after the first -> rejected, HP stays 150; after 30 frame ticks immune_our=0, next hit_our (dmg 50) -> 100.
REQ-036 HP_enemy_state=20, hit_enemy with dmg_enemy=255 -> HP_enemy_state=0 (no wrap), round_state=2; later hits ignored.
REQ-037 hit_our and hit_enemy in the same cycle, both with damage >= their HP -> both outputs 0, round_state=2; then new_game -> both 200, round_state=1.
REQ-038 new_game and hit_our (dmg 50) in the same cycle -> HP_our_state=200, immune_our=0; rst during PLAYING -> round_state=0, HP=200, hits ignored.
